// File: rtl/updown_counter_ranged.sv
// ---------------------------------------------------------------------------
// updown_counter_ranged
//
// Up/down counter with a programmable step, confined to the inclusive range
// [MIN_VAL, MAX_VAL]. A step that would leave the range is a "crossing": it
// wraps to the opposite bound (WRAP_MODE=1) or saturates at the bound it hit
// (WRAP_MODE=0). Every crossing raises wrap_evt for one cycle and sets the
// matching sticky flag.
//
// Synchronous priority per rising edge: clear > load > en > hold.
//
// Ports:
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset (value <= INIT_VAL, flags <= 0)
//   clear       synchronous return to INIT_VAL (sticky flags kept)
//   load        synchronous load of load_val, clamped into the range
//   load_val    value to load
//   en          count enable
//   inst        direction: 0 = up, 1 = down
//   step        increment/decrement amount (0 = hold)
//   clr_flags   clears ovf_sticky/udf_sticky (a same-cycle crossing wins)
//   value       registered count
//   at_max      value == MAX_VAL
//   at_min      value == MIN_VAL
//   wrap_evt    one-cycle pulse after an edge that performed a crossing
//   ovf_sticky  an up-crossing occurred since the flags were last cleared
//   udf_sticky  a down-crossing occurred since the flags were last cleared
//
// Optional build macro UPDOWN_BOUNDS_CHECK_EN adds simulation-only checks
// (range of value, no back-to-back same-direction wraps in wrap mode).
// Requires MIN_VAL <= INIT_VAL <= MAX_VAL and STEP_W <= WIDTH.
// ---------------------------------------------------------------------------
module updown_counter_ranged #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      STEP_W    = 4,
    parameter logic [WIDTH-1:0] MIN_VAL   = '0,
    parameter logic [WIDTH-1:0] MAX_VAL   = '1,
    parameter logic [WIDTH-1:0] INIT_VAL  = MIN_VAL,
    parameter bit               WRAP_MODE = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              en,
    input  logic              inst,
    input  logic [STEP_W-1:0] step,
    input  logic              clr_flags,
    output logic [WIDTH-1:0]  value,
    output logic              at_max,
    output logic              at_min,
    output logic              wrap_evt,
    output logic              ovf_sticky,
    output logic              udf_sticky
);

    localparam logic [WIDTH:0] MIN_X = {1'b0, MIN_VAL};
    localparam logic [WIDTH:0] MAX_X = {1'b0, MAX_VAL};

    // Unsigned a < b via the borrow of a one-bit-wider subtraction. Used
    // instead of relational operators so that a bound of zero does not turn
    // into a constant comparison.
    function automatic logic lt(input logic [WIDTH:0] a, input logic [WIDTH:0] b);
        logic [WIDTH+1:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[WIDTH+1];
    endfunction

    logic [WIDTH:0]   val_x;
    logic [WIDTH:0]   step_x;
    logic [WIDTH:0]   sum_x;
    logic [WIDTH:0]   floor_x;
    logic [WIDTH:0]   load_x;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] next_val;
    logic             counting;
    logic             up_evt;
    logic             dn_evt;

    assign val_x   = {1'b0, value};
    assign step_x  = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    assign load_x  = {1'b0, load_val};
    // Both are WIDTH+1 bits wide, so neither the sum nor the lower
    // threshold can overflow.
    assign sum_x   = val_x + step_x;
    assign floor_x = MIN_X + step_x;

    // Crossings only happen on an enabled count that is not pre-empted by
    // clear or load.
    assign counting = !clear && !load && en;
    assign up_evt   = counting && !inst && lt(MAX_X, sum_x);
    assign dn_evt   = counting &&  inst && lt(val_x, floor_x);

    always_comb begin
        load_clamped = load_val;
        if (lt(load_x, MIN_X)) begin
            load_clamped = MIN_VAL;
        end else if (lt(MAX_X, load_x)) begin
            load_clamped = MAX_VAL;
        end
    end

    always_comb begin
        next_val = value;
        if (clear) begin
            next_val = INIT_VAL;
        end else if (load) begin
            next_val = load_clamped;
        end else if (en) begin
            if (up_evt) begin
                next_val = WRAP_MODE ? MIN_VAL : MAX_VAL;
            end else if (dn_evt) begin
                next_val = WRAP_MODE ? MAX_VAL : MIN_VAL;
            end else if (!inst) begin
                next_val = sum_x[WIDTH-1:0];
            end else begin
                next_val = value - step_x[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value      <= INIT_VAL;
            wrap_evt   <= 1'b0;
            ovf_sticky <= 1'b0;
            udf_sticky <= 1'b0;
        end else begin
            value      <= next_val;
            wrap_evt   <= up_evt || dn_evt;
            // A crossing in the same cycle as clr_flags leaves the flag set.
            ovf_sticky <= (ovf_sticky && !clr_flags) || up_evt;
            udf_sticky <= (udf_sticky && !clr_flags) || dn_evt;
        end
    end

    assign at_max = (value == MAX_VAL);
    assign at_min = (value == MIN_VAL);

`ifdef UPDOWN_BOUNDS_CHECK_EN
    // Direction of the crossing that produced the current wrap_evt pulse.
    // A wrap lands on a bound, so with step <= MAX_VAL-MIN_VAL an immediate
    // second crossing is only legal in the opposite direction.
    logic chk_last_up;

    always @(posedge clock) begin
        if (reset_n) begin
            if (lt(val_x, MIN_X) || lt(MAX_X, val_x)) begin
                $display("ASSERTION FAILED: value %0d outside [%0d, %0d]",
                         value, MIN_VAL, MAX_VAL);
                $finish;
            end
            if (WRAP_MODE && wrap_evt && (up_evt || dn_evt) &&
                (up_evt == chk_last_up) && !lt(MAX_X - MIN_X, step_x)) begin
                $display("ASSERTION FAILED: wrap_evt high in consecutive cycles");
                $finish;
            end
            chk_last_up <= up_evt;
        end
    end
`endif

endmodule

// File: tb/tb_updown_counter_ranged.sv
// ---------------------------------------------------------------------------
// Bench for updown_counter_ranged. Three instances share the clock and reset:
//   d0: [2,9], INIT 2, wrap      d1: [0,9], INIT 0, saturate
//   d2: [5,5], INIT 5, wrap (degenerate range)
// Each has its own inputs and its own integer reference model.
// ---------------------------------------------------------------------------
module tb_updown_counter_ranged;

    localparam int N = 3;

    int cmin [N] = '{2, 0, 5};
    int cmax [N] = '{9, 9, 5};
    int cinit[N] = '{2, 0, 5};
    bit cwrap[N] = '{1'b1, 1'b0, 1'b1};

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    logic       i_clear[N];
    logic       i_load [N];
    logic [7:0] i_lv   [N];
    logic       i_en   [N];
    logic       i_inst [N];
    logic [3:0] i_step [N];
    logic       i_clrf [N];

    logic [7:0] o_val[N];
    logic       o_max[N];
    logic       o_min[N];
    logic       o_evt[N];
    logic       o_ovf[N];
    logic       o_udf[N];

    int m_val[N];
    bit m_evt[N];
    bit m_ovf[N];
    bit m_udf[N];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    updown_counter_ranged #(
        .WIDTH(8), .STEP_W(4), .MIN_VAL(8'd2), .MAX_VAL(8'd9),
        .INIT_VAL(8'd2), .WRAP_MODE(1'b1)
    ) dut0 (
        .clock(clock), .reset_n(reset_n), .clear(i_clear[0]), .load(i_load[0]),
        .load_val(i_lv[0]), .en(i_en[0]), .inst(i_inst[0]), .step(i_step[0]),
        .clr_flags(i_clrf[0]), .value(o_val[0]), .at_max(o_max[0]),
        .at_min(o_min[0]), .wrap_evt(o_evt[0]), .ovf_sticky(o_ovf[0]),
        .udf_sticky(o_udf[0])
    );

    updown_counter_ranged #(
        .WIDTH(8), .STEP_W(4), .MIN_VAL(8'd0), .MAX_VAL(8'd9),
        .INIT_VAL(8'd0), .WRAP_MODE(1'b0)
    ) dut1 (
        .clock(clock), .reset_n(reset_n), .clear(i_clear[1]), .load(i_load[1]),
        .load_val(i_lv[1]), .en(i_en[1]), .inst(i_inst[1]), .step(i_step[1]),
        .clr_flags(i_clrf[1]), .value(o_val[1]), .at_max(o_max[1]),
        .at_min(o_min[1]), .wrap_evt(o_evt[1]), .ovf_sticky(o_ovf[1]),
        .udf_sticky(o_udf[1])
    );

    updown_counter_ranged #(
        .WIDTH(8), .STEP_W(4), .MIN_VAL(8'd5), .MAX_VAL(8'd5),
        .INIT_VAL(8'd5), .WRAP_MODE(1'b1)
    ) dut2 (
        .clock(clock), .reset_n(reset_n), .clear(i_clear[2]), .load(i_load[2]),
        .load_val(i_lv[2]), .en(i_en[2]), .inst(i_inst[2]), .step(i_step[2]),
        .clr_flags(i_clrf[2]), .value(o_val[2]), .at_max(o_max[2]),
        .at_min(o_min[2]), .wrap_evt(o_evt[2]), .ovf_sticky(o_ovf[2]),
        .udf_sticky(o_udf[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        for (int k = 0; k < N; k++) begin
            i_clear[k] = 1'b0; i_load[k] = 1'b0; i_lv[k] = 8'd0;
            i_en[k] = 1'b0; i_inst[k] = 1'b0; i_step[k] = 4'd0; i_clrf[k] = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_val[k] = cinit[k]; m_evt[k] = 1'b0; m_ovf[k] = 1'b0; m_udf[k] = 1'b0;
        end
    endtask

    // Reference behaviour for one rising edge, from the range rules.
    task automatic model_edge();
        for (int k = 0; k < N; k++) begin
            int s;
            int lv;
            int nv;
            bit up;
            bit dn;
            s  = int'(i_step[k]);
            lv = int'(i_lv[k]);
            nv = m_val[k];
            up = 1'b0;
            dn = 1'b0;
            if (i_clear[k]) begin
                nv = cinit[k];
            end else if (i_load[k]) begin
                nv = (lv < cmin[k]) ? cmin[k] : (lv > cmax[k]) ? cmax[k] : lv;
            end else if (i_en[k]) begin
                if (!i_inst[k]) begin
                    if (m_val[k] + s > cmax[k]) begin
                        up = 1'b1;
                        nv = cwrap[k] ? cmin[k] : cmax[k];
                    end else begin
                        nv = m_val[k] + s;
                    end
                end else begin
                    if (m_val[k] - s < cmin[k]) begin
                        dn = 1'b1;
                        nv = cwrap[k] ? cmax[k] : cmin[k];
                    end else begin
                        nv = m_val[k] - s;
                    end
                end
            end
            m_val[k] = nv;
            m_evt[k] = up | dn;
            m_ovf[k] = (m_ovf[k] & ~i_clrf[k]) | up;
            m_udf[k] = (m_udf[k] & ~i_clrf[k]) | dn;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < N; k++) begin
            chk($sformatf("d%0d.value", k),  32'(o_val[k]), 32'(m_val[k]));
            chk($sformatf("d%0d.at_max", k), 32'(o_max[k]), 32'(m_val[k] == cmax[k]));
            chk($sformatf("d%0d.at_min", k), 32'(o_min[k]), 32'(m_val[k] == cmin[k]));
            chk($sformatf("d%0d.wrap_evt", k), 32'(o_evt[k]), 32'(m_evt[k]));
            chk($sformatf("d%0d.ovf", k),    32'(o_ovf[k]), 32'(m_ovf[k]));
            chk($sformatf("d%0d.udf", k),    32'(o_udf[k]), 32'(m_udf[k]));
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
        check_all();
    endtask

    // Called 1 time unit after an edge: asserts reset mid-cycle, checks the
    // immediate effect, and releases it well before the next edge.
    task automatic async_reset_pulse();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #3 reset_n = 1'b1;
    endtask

    initial begin
        idle();
        model_reset();
        #12;
        check_all();
        reset_n = 1'b1;

        // d0 up by 3: 5, 8, then crossing to MIN
        i_en[0] = 1'b1; i_step[0] = 4'd3;
        tick(); chk("d0 up 5", 32'(o_val[0]), 32'd5);
        tick(); chk("d0 up 8", 32'(o_val[0]), 32'd8);
        tick(); chk("d0 wrap to 2", 32'(o_val[0]), 32'd2);
        chk("d0 wrap_evt", 32'(o_evt[0]), 32'd1);
        chk("d0 ovf set", 32'(o_ovf[0]), 32'd1);
        i_en[0] = 1'b0;
        tick(); chk("d0 evt one cycle", 32'(o_evt[0]), 32'd0);

        // d0 down by 1 from MIN wraps to MAX
        i_en[0] = 1'b1; i_inst[0] = 1'b1; i_step[0] = 4'd1;
        tick(); chk("d0 down wrap 9", 32'(o_val[0]), 32'd9);
        chk("d0 udf set", 32'(o_udf[0]), 32'd1);
        chk("d0 at_max", 32'(o_max[0]), 32'd1);
        i_en[0] = 1'b0; i_clrf[0] = 1'b1;
        tick(); chk("d0 clr ovf", 32'(o_ovf[0]), 32'd0);
        chk("d0 clr udf", 32'(o_udf[0]), 32'd0);
        i_clrf[0] = 1'b0;

        // d1 saturating up by 4: 4, 8, 9, 9
        i_en[1] = 1'b1; i_step[1] = 4'd4;
        tick(); chk("d1 sat 4", 32'(o_val[1]), 32'd4);
        tick(); chk("d1 sat 8", 32'(o_val[1]), 32'd8);
        tick(); chk("d1 sat 9a", 32'(o_val[1]), 32'd9);
        chk("d1 evt a", 32'(o_evt[1]), 32'd1);
        tick(); chk("d1 sat 9b", 32'(o_val[1]), 32'd9);
        chk("d1 evt b", 32'(o_evt[1]), 32'd1);
        chk("d1 at_max", 32'(o_max[1]), 32'd1);
        i_en[1] = 1'b0;

        // d0 loads with clamping, then clear beats load
        i_load[0] = 1'b1; i_lv[0] = 8'd200;
        tick(); chk("d0 load clamp hi", 32'(o_val[0]), 32'd9);
        i_lv[0] = 8'd0;
        tick(); chk("d0 load clamp lo", 32'(o_val[0]), 32'd2);
        i_lv[0] = 8'd7;
        tick(); chk("d0 load 7", 32'(o_val[0]), 32'd7);
        i_lv[0] = 8'd5; i_clear[0] = 1'b1;
        tick(); chk("d0 clear wins", 32'(o_val[0]), 32'd2);
        idle();

        // crossing and clr_flags in the same cycle: the set wins
        i_en[0] = 1'b1; i_inst[0] = 1'b1; i_step[0] = 4'd1; i_clrf[0] = 1'b1;
        tick(); chk("d0 set beats clr", 32'(o_udf[0]), 32'd1);
        idle();

        // degenerate range: any nonzero step is a crossing
        i_en[2] = 1'b1; i_step[2] = 4'd1;
        tick(); chk("d2 up evt", 32'(o_evt[2]), 32'd1);
        i_inst[2] = 1'b1; i_step[2] = 4'd3;
        tick(); chk("d2 dn udf", 32'(o_udf[2]), 32'd1);
        i_step[2] = 4'd0;
        tick(); chk("d2 step0 no evt", 32'(o_evt[2]), 32'd0);
        idle();

        // reset between edges while counting, then resume from INIT
        i_en[0] = 1'b1; i_step[0] = 4'd1;
        tick(); tick();
        async_reset_pulse();
        chk("d0 after reset", 32'(o_val[0]), 32'd2);
        tick(); chk("d0 resume", 32'(o_val[0]), 32'd3);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                i_clear[k] = ($urandom_range(31) == 0);
                i_load[k]  = ($urandom_range(15) == 0);
                i_lv[k]    = 8'($urandom_range(255));
                i_en[k]    = ($urandom_range(3) != 0);
                i_inst[k]  = 1'($urandom_range(1));
                i_step[k]  = 4'($urandom_range(15));
                i_clrf[k]  = ($urandom_range(7) == 0);
            end
            tick();
            if ($urandom_range(399) == 0) async_reset_pulse();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
